// File: rtl/dma_cache_pingpong_ctrl.sv
// Ping-pong beat-cache sequencer: the fill side writes one buffer while the drain side reads the other.
// Buffers hand over strictly in order, and both sides can run at one beat per cycle.

module dma_pp_buf #(
  parameter int IDX_W  = 4,
  parameter int BYTE_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              clr,
  input  logic              fill_acc,
  input  logic              fill_first,
  input  logic              fill_done,
  input  logic [BYTE_W-1:0] fill_bytes,
  input  logic [IDX_W:0]    fill_beats,
  input  logic              drain_acc,
  input  logic              drain_done,
  output logic              avail,
  output logic [IDX_W:0]    beats,
  output logic [CNT_W-1:0]  bytes
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} buf_st_e;
  buf_st_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (fill_acc) begin
      if (fill_done)              state_d = FULL;
      else if (state_q == EMPTY)  state_d = FILLING;
    end
    if (drain_acc) begin
      if (drain_done)             state_d = EMPTY;
      else if (state_q == FULL)   state_d = DRAINING;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q <= EMPTY;
      beats   <= '0;
      bytes   <= '0;
    end else if (clr) begin
      state_q <= EMPTY;
      beats   <= '0;
      bytes   <= '0;
    end else begin
      state_q <= state_d;
      // First beat of a fill reloads the total so stale counts never leak in.
      if (fill_acc) bytes <= fill_first ? CNT_W'(fill_bytes) : bytes + CNT_W'(fill_bytes);
      if (fill_acc && fill_done) beats <= fill_beats;
    end
  end

  assign avail = (state_q == FULL) || (state_q == DRAINING);
endmodule

module dma_cache_pingpong_ctrl #(
  parameter  int BEAT_BYTES  = 8,
  parameter  int CACHE_DEPTH = 16,
  localparam int IDX_W  = $clog2(CACHE_DEPTH),
  localparam int BYTE_W = $clog2(BEAT_BYTES + 1),
  localparam int CNT_W  = $clog2(BEAT_BYTES * CACHE_DEPTH + 1)
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  input  logic              CLR,
  input  logic              src_beat_valid,
  input  logic [BYTE_W-1:0] src_beat_bytes,
  input  logic              src_last,
  output logic              src_ready,
  output logic              cache_wr_en,
  output logic              cache_wr_sel,
  output logic [IDX_W-1:0]  cache_wr_addr,
  output logic              dst_rd_valid,
  input  logic              dst_rd_ready,
  output logic              dst_rd_last,
  output logic [CNT_W-1:0]  dst_buf_bytes,
  output logic              cache_rd_sel,
  output logic [IDX_W-1:0]  cache_rd_addr,
  output logic [1:0]        occupancy
);
  logic                  fsel, dsel;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [1:0]            avail;
  logic [1:0][IDX_W:0]   beats;
  logic [1:0][CNT_W-1:0] bytes;
  logic [IDX_W:0]        last_idx, fill_beats;
  logic                  fill_done, drain_acc, drain_done;

  assign src_ready   = ~avail[fsel] & ~CLR;
  assign cache_wr_en = src_beat_valid & src_ready;
  assign fill_done   = cache_wr_en & (src_last | (wr_idx == IDX_W'(CACHE_DEPTH - 1)));
  assign fill_beats  = {1'b0, wr_idx} + 1'b1;

  assign dst_rd_valid  = avail[dsel];
  assign last_idx      = beats[dsel] - 1'b1;
  assign dst_rd_last   = ({1'b0, rd_idx} == last_idx);
  assign dst_buf_bytes = bytes[dsel];
  assign drain_acc     = dst_rd_valid & dst_rd_ready;
  assign drain_done    = drain_acc & dst_rd_last;

  assign occupancy     = {1'b0, avail[0]} + {1'b0, avail[1]};
  assign cache_wr_sel  = fsel;
  assign cache_wr_addr = wr_idx;
  assign cache_rd_sel  = dsel;
  assign cache_rd_addr = rd_idx;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    dma_pp_buf #(.IDX_W(IDX_W), .BYTE_W(BYTE_W), .CNT_W(CNT_W)) u_buf (
      .gclk       (CLOCK),
      .grst_n     (RESETN),
      .clr        (CLR),
      .fill_acc   (cache_wr_en & (fsel == 1'(b))),
      .fill_first (wr_idx == '0),
      .fill_done  (fill_done),
      .fill_bytes (src_beat_bytes),
      .fill_beats (fill_beats),
      .drain_acc  (drain_acc & (dsel == 1'(b))),
      .drain_done (drain_done),
      .avail      (avail[b]),
      .beats      (beats[b]),
      .bytes      (bytes[b])
    );
  end

  // Fill and drain always target different buffers, so their pointer updates are independent.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      fsel   <= 1'b0;
      dsel   <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else if (CLR) begin
      fsel   <= 1'b0;
      dsel   <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (cache_wr_en) begin
        wr_idx <= fill_done ? '0 : wr_idx + 1'b1;
        fsel   <= fsel ^ fill_done;
      end
      if (drain_acc) begin
        rd_idx <= drain_done ? '0 : rd_idx + 1'b1;
        dsel   <= dsel ^ drain_done;
      end
    end
  end
endmodule

// File: tb/tb_dma_cache_pingpong_ctrl.sv
// Directed bench for the ping-pong cache sequencer at BEAT_BYTES=8, CACHE_DEPTH=4.
module tb_dma_cache_pingpong_ctrl;
  logic       clk, rst_n, clr;
  logic       src_beat_valid, src_last, src_ready, cache_wr_en, cache_wr_sel;
  logic [3:0] src_beat_bytes;
  logic [1:0] cache_wr_addr, cache_rd_addr, occupancy;
  logic       dst_rd_valid, dst_rd_ready, dst_rd_last, cache_rd_sel;
  logic [5:0] dst_buf_bytes;
  int n_chk = 0;
  int n_fail = 0;

  dma_cache_pingpong_ctrl #(.BEAT_BYTES(8), .CACHE_DEPTH(4)) dut (
    .CLOCK(clk), .RESETN(rst_n), .CLR(clr),
    .src_beat_valid(src_beat_valid), .src_beat_bytes(src_beat_bytes), .src_last(src_last),
    .src_ready(src_ready), .cache_wr_en(cache_wr_en), .cache_wr_sel(cache_wr_sel),
    .cache_wr_addr(cache_wr_addr), .dst_rd_valid(dst_rd_valid), .dst_rd_ready(dst_rd_ready),
    .dst_rd_last(dst_rd_last), .dst_buf_bytes(dst_buf_bytes), .cache_rd_sel(cache_rd_sel),
    .cache_rd_addr(cache_rd_addr), .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; clr = 1'b0; src_beat_valid = 1'b0; src_beat_bytes = 4'd8;
    src_last = 1'b0; dst_rd_ready = 1'b0;
    #3 rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; clr = 1'b0; src_beat_valid = 1'b0; src_beat_bytes = 4'd8;
    src_last = 1'b0; dst_rd_ready = 1'b0;
    #2;
    n_chk++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL reset_src_ready got=%0d exp=1", src_ready); end
    n_chk++; if (cache_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%0d exp=0", cache_wr_en); end
    #2 rst_n = 1'b1;
    cyc(); cyc();
    n_chk++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL idle_src_ready got=%0d exp=1", src_ready); end
    n_chk++; if (dst_rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rd_valid got=%0d exp=0", dst_rd_valid); end
    n_chk++; if (dst_rd_last !== 1'b0) begin n_fail++; $display("FAIL idle_rd_last got=%0d exp=0", dst_rd_last); end
    n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL idle_occupancy got=%0d exp=0", occupancy); end
    n_chk++; if (dst_buf_bytes !== 6'd0) begin n_fail++; $display("FAIL idle_buf_bytes got=%0d exp=0", dst_buf_bytes); end
    n_chk++; if ({cache_wr_sel, cache_wr_addr, cache_rd_sel, cache_rd_addr} !== 6'd0) begin
      n_fail++; $display("FAIL idle_sel_addr got=%b exp=000000", {cache_wr_sel, cache_wr_addr, cache_rd_sel, cache_rd_addr}); end
  endtask

  task automatic test_full_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_beat_valid = 1'b1; src_beat_bytes = 4'd8; src_last = 1'b0;
      #1;
      n_chk++; if (cache_wr_en !== 1'b1 || cache_wr_sel !== 1'b0 || cache_wr_addr !== 2'(i)) begin
        n_fail++; $display("FAIL fill4_write beat=%0d got en=%0d sel=%0d addr=%0d exp en=1 sel=0 addr=%0d", i, cache_wr_en, cache_wr_sel, cache_wr_addr, i); end
      cyc();
    end
    src_beat_valid = 1'b0;
    #1;
    n_chk++; if (dst_rd_valid !== 1'b1) begin n_fail++; $display("FAIL fill4_rd_valid got=%0d exp=1", dst_rd_valid); end
    n_chk++; if (dst_buf_bytes !== 6'd32) begin n_fail++; $display("FAIL fill4_bytes got=%0d exp=32", dst_buf_bytes); end
    n_chk++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL fill4_occupancy got=%0d exp=1", occupancy); end
    n_chk++; if (cache_wr_sel !== 1'b1) begin n_fail++; $display("FAIL fill4_fsel got=%0d exp=1", cache_wr_sel); end
    for (int j = 0; j < 4; j++) begin
      dst_rd_ready = 1'b1;
      #1;
      n_chk++; if (cache_rd_sel !== 1'b0 || cache_rd_addr !== 2'(j) || dst_rd_last !== (j == 3)) begin
        n_fail++; $display("FAIL drain4 beat=%0d got sel=%0d addr=%0d last=%0d exp sel=0 addr=%0d last=%0d", j, cache_rd_sel, cache_rd_addr, dst_rd_last, j, (j == 3)); end
      cyc();
    end
    dst_rd_ready = 1'b0;
    #1;
    n_chk++; if (occupancy !== 2'd0 || dst_rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain4_done got occ=%0d valid=%0d exp occ=0 valid=0", occupancy, dst_rd_valid); end
    n_chk++; if (cache_rd_sel !== 1'b1) begin n_fail++; $display("FAIL drain4_dsel got=%0d exp=1", cache_rd_sel); end
  endtask

  task automatic test_short_fill();
    do_reset();
    src_beat_valid = 1'b1; src_beat_bytes = 4'd8; src_last = 1'b0;
    #1;
    n_chk++; if (cache_wr_addr !== 2'd0) begin n_fail++; $display("FAIL short_addr0 got=%0d exp=0", cache_wr_addr); end
    cyc();
    src_beat_bytes = 4'd3; src_last = 1'b1;
    #1;
    n_chk++; if (cache_wr_addr !== 2'd1 || cache_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL short_addr1 got addr=%0d en=%0d exp addr=1 en=1", cache_wr_addr, cache_wr_en); end
    cyc();
    src_beat_valid = 1'b0; src_last = 1'b0;
    #1;
    n_chk++; if (dst_buf_bytes !== 6'd11) begin n_fail++; $display("FAIL short_bytes got=%0d exp=11", dst_buf_bytes); end
    n_chk++; if (dst_rd_valid !== 1'b1 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL short_valid got valid=%0d occ=%0d exp valid=1 occ=1", dst_rd_valid, occupancy); end
    for (int j = 0; j < 2; j++) begin
      dst_rd_ready = 1'b1;
      #1;
      n_chk++; if (cache_rd_addr !== 2'(j) || dst_rd_last !== (j == 1)) begin
        n_fail++; $display("FAIL short_drain beat=%0d got addr=%0d last=%0d exp addr=%0d last=%0d", j, cache_rd_addr, dst_rd_last, j, (j == 1)); end
      cyc();
    end
    dst_rd_ready = 1'b0;
    #1;
    n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL short_done_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      src_beat_valid = 1'b1; src_beat_bytes = 4'd8; src_last = 1'b0;
      #1;
      n_chk++; if (src_ready !== 1'b1 || cache_wr_sel !== 1'(i / 4) || cache_wr_addr !== 2'(i % 4)) begin
        n_fail++; $display("FAIL bp_fill beat=%0d got rdy=%0d sel=%0d addr=%0d exp rdy=1 sel=%0d addr=%0d", i, src_ready, cache_wr_sel, cache_wr_addr, i / 4, i % 4); end
      cyc();
    end
    #1;
    n_chk++; if (src_ready !== 1'b0 || cache_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall got rdy=%0d en=%0d exp rdy=0 en=0", src_ready, cache_wr_en); end
    n_chk++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occupancy got=%0d exp=2", occupancy); end
    cyc();
    #1;
    n_chk++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_hold got=%0d exp=0", src_ready); end
    for (int j = 0; j < 4; j++) begin
      dst_rd_ready = 1'b1;
      #1;
      n_chk++; if (cache_rd_sel !== 1'b0 || cache_rd_addr !== 2'(j) || dst_rd_last !== (j == 3) || src_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_drain beat=%0d got sel=%0d addr=%0d last=%0d rdy=%0d exp sel=0 addr=%0d last=%0d rdy=0", j, cache_rd_sel, cache_rd_addr, dst_rd_last, src_ready, j, (j == 3)); end
      cyc();
    end
    dst_rd_ready = 1'b0;
    #1;
    n_chk++; if (src_ready !== 1'b1 || cache_wr_en !== 1'b1 || cache_wr_sel !== 1'b0 || cache_wr_addr !== 2'd0) begin
      n_fail++; $display("FAIL bp_resume got rdy=%0d en=%0d sel=%0d addr=%0d exp rdy=1 en=1 sel=0 addr=0", src_ready, cache_wr_en, cache_wr_sel, cache_wr_addr); end
    n_chk++; if (occupancy !== 2'd1 || cache_rd_sel !== 1'b1) begin
      n_fail++; $display("FAIL bp_after_drain got occ=%0d dsel=%0d exp occ=1 dsel=1", occupancy, cache_rd_sel); end
    cyc();
    src_beat_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int mem [2][4];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int stalls = 0;
    int bad = 0;
    do_reset();
    for (int c = 0; c < 84; c++) begin
      src_beat_valid = (c < 80); src_beat_bytes = 4'd8; src_last = 1'b0; dst_rd_ready = 1'b1;
      #1;
      if (c < 80 && !cache_wr_en) stalls++;
      if (dst_rd_valid) begin
        n_chk++;
        if (cache_rd_sel !== 1'((rd_cnt / 4) % 2) || cache_rd_addr !== 2'(rd_cnt % 4) ||
            mem[cache_rd_sel][cache_rd_addr] != rd_cnt || dst_rd_last !== (rd_cnt % 4 == 3) || dst_buf_bytes !== 6'd32) begin
          n_fail++; bad++;
          if (bad < 5) $display("FAIL stream_drain beat=%0d got sel=%0d addr=%0d data=%0d last=%0d bytes=%0d", rd_cnt, cache_rd_sel, cache_rd_addr, mem[cache_rd_sel][cache_rd_addr], dst_rd_last, dst_buf_bytes);
        end
        rd_cnt++;
      end
      if (cache_wr_en) begin
        n_chk++;
        if (cache_wr_sel !== 1'((wr_cnt / 4) % 2) || cache_wr_addr !== 2'(wr_cnt % 4)) begin
          n_fail++; bad++;
          if (bad < 5) $display("FAIL stream_fill beat=%0d got sel=%0d addr=%0d exp sel=%0d addr=%0d", wr_cnt, cache_wr_sel, cache_wr_addr, (wr_cnt / 4) % 2, wr_cnt % 4);
        end
        if (wr_cnt >= 7 && wr_cnt % 4 == 3) begin
          n_chk++;
          if (dst_rd_valid !== 1'b1 || dst_rd_last !== 1'b1) begin
            n_fail++; $display("FAIL stream_same_edge beat=%0d got valid=%0d last=%0d exp 1 1", wr_cnt, dst_rd_valid, dst_rd_last); end
        end
        mem[cache_wr_sel][cache_wr_addr] = wr_cnt;
        wr_cnt++;
      end
      cyc();
    end
    src_beat_valid = 1'b0; dst_rd_ready = 1'b0;
    #1;
    n_chk++; if (stalls != 0) begin n_fail++; $display("FAIL stream_stalls got=%0d exp=0", stalls); end
    n_chk++; if (wr_cnt != 80 || rd_cnt != 80) begin n_fail++; $display("FAIL stream_counts got wr=%0d rd=%0d exp 80 80", wr_cnt, rd_cnt); end
    n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_clr();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      src_beat_valid = (i < 5); src_beat_bytes = 4'd8; src_last = 1'b0; dst_rd_ready = (i >= 4);
      cyc();
    end
    clr = 1'b1; src_beat_valid = 1'b1; dst_rd_ready = 1'b0;
    #1;
    n_chk++; if (cache_rd_addr !== 2'd2 || cache_wr_addr !== 2'd1 || cache_wr_sel !== 1'b1 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL clr_setup got rd=%0d wr=%0d wsel=%0d occ=%0d exp 2 1 1 1", cache_rd_addr, cache_wr_addr, cache_wr_sel, occupancy); end
    n_chk++; if (src_ready !== 1'b0 || cache_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL clr_block got rdy=%0d en=%0d exp 0 0", src_ready, cache_wr_en); end
    cyc();
    clr = 1'b0; src_beat_valid = 1'b0;
    #1;
    n_chk++; if (occupancy !== 2'd0 || dst_rd_valid !== 1'b0 || src_ready !== 1'b1 || dst_buf_bytes !== 6'd0) begin
      n_fail++; $display("FAIL clr_state got occ=%0d valid=%0d rdy=%0d bytes=%0d exp 0 0 1 0", occupancy, dst_rd_valid, src_ready, dst_buf_bytes); end
    n_chk++; if ({cache_wr_sel, cache_wr_addr, cache_rd_sel, cache_rd_addr} !== 6'd0) begin
      n_fail++; $display("FAIL clr_ptrs got=%b exp=000000", {cache_wr_sel, cache_wr_addr, cache_rd_sel, cache_rd_addr}); end
    src_beat_valid = 1'b1; src_beat_bytes = 4'd5; src_last = 1'b1;
    cyc();
    src_beat_valid = 1'b0; src_last = 1'b0;
    #1;
    n_chk++; if (dst_buf_bytes !== 6'd5 || dst_rd_last !== 1'b1 || cache_rd_sel !== 1'b0) begin
      n_fail++; $display("FAIL clr_refill got bytes=%0d last=%0d dsel=%0d exp 5 1 0", dst_buf_bytes, dst_rd_last, cache_rd_sel); end
  endtask

  initial begin
    rst_n = 1'b1; clr = 1'b0; src_beat_valid = 1'b0; src_beat_bytes = 4'd8;
    src_last = 1'b0; dst_rd_ready = 1'b0;
    test_reset();
    test_full_fill_drain();
    test_short_fill();
    test_backpressure();
    test_back_to_back();
    test_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
